// File: rtl/fpu_divider.sv
// Iterative radix-2 restoring divider for normalized FP32 significands (1.xxx / 1.xxx).
// Optional FPU_DIV_EARLY_TERM_EN: finish as soon as the partial remainder reaches zero.
module fpu_divider #(
    parameter int unsigned QBITS = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [23:0]      dividend_i,
    input  logic [23:0]      divisor_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [QBITS-1:0] quotient_o,
    output logic             sticky_o,
    output logic             div_by_zero_o
);

    localparam int unsigned SIG_W = 24;
    localparam int unsigned REM_W = SIG_W + 1;
    localparam int unsigned CNT_W = $clog2(QBITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [SIG_W-1:0]   dvsr_q, dvsr_d;
    logic [QBITS-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [QBITS-1:0]   quotient_q, quotient_d;
    logic               sticky_q, sticky_d;
    logic               dbz_q, dbz_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    // One restoring step: trial subtract, keep it only if it did not go negative.
    logic               rem_ge;
    logic [REM_W-1:0]   rem_sub;
    logic [QBITS-1:0]   q_step;
    logic               early_done;

    assign rem_ge  = (rem_q >= REM_W'(dvsr_q));
    assign rem_sub = rem_ge ? (rem_q - REM_W'(dvsr_q)) : rem_q;
    assign q_step  = q_q | (QBITS'(rem_ge) << cnt_q);

`ifdef FPU_DIV_EARLY_TERM_EN
    assign early_done = rem_ge && (rem_sub == '0);
`else
    assign early_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            dvsr_q      <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            sticky_q    <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            sticky_q    <= sticky_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        quotient_d = quotient_q;
        sticky_d   = sticky_q;
        dbz_d      = dbz_q;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        if (divisor_i == '0) begin
                            quotient_d = '1;
                            sticky_d   = 1'b0;
                            dbz_d      = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            rem_d   = {1'b0, dividend_i};
                            dvsr_d  = divisor_i;
                            q_d     = '0;
                            cnt_d   = CNT_W'(QBITS - 1);
                            dbz_d   = 1'b0;
                            state_d = S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    q_d   = q_step;
                    rem_d = {rem_sub[REM_W-2:0], 1'b0};
                    cnt_d = cnt_q - CNT_W'(1);
                    if ((cnt_q == '0) || early_done) begin
                        quotient_d = q_step;
                        sticky_d   = |rem_sub;
                        state_d    = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign quotient_o    = quotient_q;
    assign sticky_o      = sticky_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_fpu_divider.sv
// Directed and model-checked bench for fpu_divider (default and early-termination builds).
module tb_fpu_divider;

    localparam int unsigned QBITS = 26;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [23:0]      dividend = '0;
    logic [23:0]      divisor = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [QBITS-1:0] quotient;
    logic             sticky;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_divider #(.QBITS(QBITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .quotient_o   (quotient),
        .sticky_o     (sticky),
        .div_by_zero_o(div_by_zero)
    );

    typedef struct {
        logic [23:0] x;
        logic [23:0] y;
        logic [25:0] q;
        logic        s;
        int          lat;
    } vec_t;

    // lat = clock edges after the accept edge until out_valid is seen high
    task automatic run_op(input logic [23:0] x, input logic [23:0] y,
                          output logic [25:0] q, output logic s, output logic z,
                          output int lat);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        dividend = x;
        divisor  = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient;
        s = sticky;
        z = div_by_zero;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (out_valid !== 1'b0 || quotient !== '0 || sticky !== 1'b0 ||
            div_by_zero !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: ov=%b q=%h s=%b dbz=%b rdy=%b required 0/0/0/0/1",
                     tag, out_valid, quotient, sticky, div_by_zero, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_vectors();
        vec_t v[6];
        logic [25:0] q;
        logic s, z;
        int lat;
`ifdef FPU_DIV_EARLY_TERM_EN
        v[0] = '{24'h800000, 24'h800000, 26'h2000000, 1'b0, 1};
        v[1] = '{24'hC00000, 24'h800000, 26'h3000000, 1'b0, 2};
        v[2] = '{24'h800000, 24'hC00000, 26'h1555555, 1'b1, 26};
        v[3] = '{24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 24};
        v[4] = '{24'hA00000, 24'h800000, 26'h2800000, 1'b0, 3};
        v[5] = '{24'hFFFFFF, 24'hFFFFFF, 26'h2000000, 1'b0, 1};
`else
        v[0] = '{24'h800000, 24'h800000, 26'h2000000, 1'b0, 26};
        v[1] = '{24'hC00000, 24'h800000, 26'h3000000, 1'b0, 26};
        v[2] = '{24'h800000, 24'hC00000, 26'h1555555, 1'b1, 26};
        v[3] = '{24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 26};
        v[4] = '{24'hA00000, 24'h800000, 26'h2800000, 1'b0, 26};
        v[5] = '{24'hFFFFFF, 24'hFFFFFF, 26'h2000000, 1'b0, 26};
`endif
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].x, v[i].y, q, s, z, lat);
            checks++;
            if (q !== v[i].q || s !== v[i].s || z !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_result: q=%h s=%b dbz=%b required q=%h s=%b dbz=0",
                         i, q, s, z, v[i].q, v[i].s);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("FAIL vec%0d_latency: %0d required %0d", i, lat, v[i].lat);
            end
            release_out();
        end
    endtask

    task automatic test_div_by_zero();
        logic [25:0] q;
        logic s, z;
        int lat;
        run_op(24'hC00000, 24'h000000, q, s, z, lat);
        checks++;
        if (q !== 26'h3FFFFFF || s !== 1'b0 || z !== 1'b1 || lat !== 0) begin
            errors++;
            $display("FAIL div_by_zero: q=%h s=%b dbz=%b lat=%0d required 3ffffff/0/1/0",
                     q, s, z, lat);
        end
        release_out();
        run_op(24'h800000, 24'hA00000, q, s, z, lat);
        checks++;
        if (q !== 26'h1999999 || s !== 1'b1 || z !== 1'b0) begin
            errors++;
            $display("FAIL dbz_cleared: q=%h s=%b dbz=%b required 1999999/1/0", q, s, z);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        logic [25:0] q;
        logic s, z;
        int lat;
        run_op(24'h800000, 24'hC00000, q, s, z, lat);
        in_valid = 1'b1;
        dividend = 24'h900000;
        divisor  = 24'h800000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 26'h1555555 ||
                sticky !== 1'b1 || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: ov=%b rdy=%b q=%h s=%b dbz=%b required 1/0/1555555/1/0",
                         i, out_valid, in_ready, quotient, sticky, div_by_zero);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_accept_on_release: rdy=%b ov=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        in_valid = 1'b1;
        dividend = 24'h800000;
        divisor  = 24'hC00000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        divisor  = 24'h000000;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: rdy=%b ov=%b dbz=%b required 1/0/0",
                     in_ready, out_valid, div_by_zero);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_result: out_valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        dividend = 24'hC00000;
        divisor  = 24'hA00000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid_iter");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("reset_mid_recover");
    endtask

    task automatic test_back_to_back();
        logic [25:0] q;
        logic s, z;
        int lat;
        run_op(24'hC00000, 24'h800000, q, s, z, lat);
        release_out();
        run_op(24'h800000, 24'h800000, q, s, z, lat);
        checks++;
        if (q !== 26'h2000000 || s !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: q=%h s=%b required 2000000/0", q, s);
        end
        release_out();
    endtask

    task automatic test_random();
        logic [25:0] q;
        logic s, z;
        int lat;
        logic [23:0] x, y;
        logic [48:0] num;
        logic [48:0] exp_q;
        logic exp_s;
        for (int i = 0; i < 200; i++) begin
            x = 24'h800000 | 24'($urandom_range(24'h7FFFFF, 0));
            y = 24'h800000 | 24'($urandom_range(24'h7FFFFF, 0));
            num   = {x, 25'b0};
            exp_q = num / 49'(y);
            exp_s = ((num % 49'(y)) != 0);
            run_op(x, y, q, s, z, lat);
            checks++;
            if (lat >= 100 || q !== exp_q[25:0] || s !== exp_s) begin
                errors++;
                $display("FAIL random%0d %h/%h: q=%h s=%b lat=%0d required q=%h s=%b",
                         i, x, y, q, s, lat, exp_q[25:0], exp_s);
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_div_by_zero();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
